// File: rtl/vadd_pkg.sv
// vadd_pkg: shared widths, state encoding and element type for the vadd kernel stages
package vadd_pkg;
  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_CNT_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mod_add_state_t;
  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;
endpackage

// File: rtl/vadd_mod_adder_reduce.sv
// mod_add_reduce: combinational (a + b) mod m for a, b < m, shared with later mod-sub/mul stages
module mod_add_reduce
  import vadd_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] r
);
  logic [W:0] sum;
  // keep the carry bit so a sum that wraps 2^W still compares correctly against the modulus
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    r = (sum >= {1'b0, modulus}) ? sum[W-1:0] - modulus : sum[W-1:0];
  end
endmodule

// File: rtl/vadd_mod_adder.sv
// vadd_mod_adder: job-bounded two-stage stallable modular adder between operand and result FIFOs
module vadd_mod_adder
  import vadd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] modulus,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_empty,
  output logic                  a_read_enable,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_empty,
  output logic                  b_read_enable,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_write_enable,
  input  logic                  s_full
);
  mod_add_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d, issued_q, issued_d, written_q, written_d;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_data_q, s2_data_d, red_r;
  logic adv, pop;

  mod_add_reduce #(.W(DATA_WIDTH)) u_reduce (
    .a(s1_a_q),
    .b(s1_b_q),
    .modulus(modulus),
    .r(red_r)
  );

  // handshakes: s_full freezes the whole pipe; both operand FIFOs pop together so pairs stay aligned
  always_comb begin
    adv = !s_full;
    pop = (state_q == RUN) && (issued_q < len_q) && !a_empty && !b_empty && adv;
    a_read_enable = pop;
    b_read_enable = pop;
    s_write_enable = s2_valid_q && adv;
    s_data = s2_data_q;
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // next state: DRAIN exits on the cycle of the final write so done follows it by exactly one cycle
  always_comb begin
    len_d = (state_q == IDLE && start) ? length : len_q;
    issued_d = (state_q == IDLE && start) ? '0 : pop ? issued_q + CNT_WIDTH'(1) : issued_q;
    written_d = (state_q == IDLE && start) ? '0 : s_write_enable ? written_q + CNT_WIDTH'(1) : written_q;
    state_d = (state_q == IDLE) ? (start ? ((length == '0) ? DONE : RUN) : IDLE) :
              (state_q == RUN) ? ((issued_q == len_q) ? DRAIN : RUN) :
              (state_q == DRAIN) ? ((written_d == len_q) ? DONE : DRAIN) : IDLE;
    s1_valid_d = adv ? pop : s1_valid_q;
    s1_a_d = (adv && pop) ? a_data : s1_a_q;
    s1_b_d = (adv && pop) ? b_data : s1_b_q;
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    s2_data_d = adv ? red_r : s2_data_q;
  end

  // state, counters and pipeline registers; reset drops any in-flight results
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      issued_q <= '0;
      written_q <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      issued_q <= issued_d;
      written_q <= written_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q <= s2_data_d;
    end
  end
endmodule

// File: tb/tb_vadd_mod_adder.sv
// tb_vadd_mod_adder: directed self-checking bench with behavioural fall-through operand FIFOs
module tb_vadd_mod_adder;
  localparam int DW = 256;
  localparam int CW = 32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic s_full = 1'b0;
  logic [CW-1:0] length = '0;
  logic [DW-1:0] modulus = '0;
  logic busy, done, a_read_enable, b_read_enable, s_write_enable, a_empty, b_empty;
  logic [DW-1:0] a_data, b_data, s_data;
  logic [DW-1:0] fa [64];
  logic [DW-1:0] fb [64];
  logic [DW-1:0] res [64];
  int res_cyc [64];
  int pop_cyc [64];
  int a_head = 0, a_tail = 0, b_head = 0, b_tail = 0;
  int cyc = 0, wr_cnt = 0, pop_cnt = 0, done_cnt = 0, done_cyc = 0, en_mis = 0;
  int passed = 0, total = 0;

  vadd_mod_adder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .length(length),
    .modulus(modulus),
    .busy(busy),
    .done(done),
    .a_data(a_data),
    .a_empty(a_empty),
    .a_read_enable(a_read_enable),
    .b_data(b_data),
    .b_empty(b_empty),
    .b_read_enable(b_read_enable),
    .s_data(s_data),
    .s_write_enable(s_write_enable),
    .s_full(s_full)
  );

  always #5 clock = ~clock;

  assign a_data = fa[a_head[5:0]];
  assign b_data = fb[b_head[5:0]];
  assign a_empty = (a_head == a_tail);
  assign b_empty = (b_head == b_tail);

  // FIFO pops and a log of every pop, write and done with its cycle number
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (a_read_enable) begin
      a_head <= a_head + 1;
      pop_cyc[pop_cnt[5:0]] <= cyc;
      pop_cnt <= pop_cnt + 1;
    end
    if (b_read_enable) b_head <= b_head + 1;
    if ((a_read_enable !== b_read_enable) || (a_read_enable && (a_empty || b_empty))) en_mis <= en_mis + 1;
    if (s_write_enable) begin
      res[wr_cnt[5:0]] <= s_data;
      res_cyc[wr_cnt[5:0]] <= cyc;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_a(input logic [DW-1:0] v);
    fa[a_tail[5:0]] = v;
    a_tail++;
  endtask

  task automatic push_b(input logic [DW-1:0] v);
    fb[b_tail[5:0]] = v;
    b_tail++;
  endtask

  task automatic go(input int n);
    start = 1'b1;
    length = n;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clock);
    check("done_seen", done_cnt, d0 + 1);
  endtask

  initial begin
    int p0, w0, w1, d0, ah;
    logic [DW-1:0] m;
    int exp3 [8] = '{8, 25, 42, 59, 76, 93, 13, 30};
    int a4 [4] = '{5, 60, 90, 33};
    int b4 [4] = '{6, 40, 10, 63};
    int exp4 [4] = '{11, 3, 3, 96};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", a_read_enable, 0);
    check("rst_wr_en", s_write_enable, 0);
    check("rst_s_data", s_data, 0);

    modulus = 97;
    push_a(10); push_b(20);
    push_a(96); push_b(1);
    push_a(50); push_b(47);
    p0 = pop_cnt; w0 = wr_cnt; d0 = done_cnt;
    @(negedge clock);
    check("idle_no_pop", pop_cnt, p0);
    go(3);
    check("busy_after_start", busy, 1);
    wait_done(d0);
    check("t1_res0", res[w0], 30);
    check("t1_res1", res[w0 + 1], 0);
    check("t1_res2", res[w0 + 2], 0);
    for (int i = 0; i < 3; i++) check("t1_latency", res_cyc[w0 + i], pop_cyc[p0 + i] + 2);
    check("t1_done_timing", done_cyc, res_cyc[w0 + 2] + 1);
    check("t1_busy_low", busy, 0);
    check("t1_done_low", done, 0);

    m = (256'd1 << 255) - 256'd19;
    modulus = m;
    push_a(m - 1); push_b(m - 1);
    w0 = wr_cnt; d0 = done_cnt;
    go(1);
    wait_done(d0);
    check("t2_carry", res[w0], m - 2);

    modulus = 97;
    for (int i = 0; i < 8; i++) begin
      push_a(10 * i + 3);
      push_b(7 * i + 5);
    end
    w0 = wr_cnt; d0 = done_cnt;
    go(8);
    start = 1'b1;
    length = 0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    s_full = 1'b1;
    p0 = pop_cnt; w1 = wr_cnt;
    @(negedge clock);
    check("stall_no_rd", a_read_enable, 0);
    check("stall_no_wr", s_write_enable, 0);
    repeat (4) @(negedge clock);
    check("stall_pops", pop_cnt, p0);
    check("stall_writes", wr_cnt, w1);
    check("stall_mid_stream", (p0 > 0 && p0 < d0 + 100) ? 1 : 0, 1);
    s_full = 1'b0;
    wait_done(d0);
    check("t3_count", wr_cnt - w0, 8);
    for (int i = 0; i < 8; i++) check("t3_res", res[w0 + i], exp3[i]);
    repeat (3) @(negedge clock);
    check("t3_single_done", done_cnt, d0 + 1);

    for (int i = 0; i < 4; i++) push_a(a4[i]);
    push_b(b4[0]);
    w0 = wr_cnt; d0 = done_cnt;
    go(4);
    repeat (2) @(negedge clock);
    p0 = pop_cnt; ah = a_head;
    repeat (3) @(negedge clock);
    check("b_empty_no_pop", pop_cnt, p0);
    check("b_empty_a_kept", a_head, ah);
    for (int i = 1; i < 4; i++) push_b(b4[i]);
    wait_done(d0);
    for (int i = 0; i < 4; i++) check("t4_res", res[w0 + i], exp4[i]);

    push_a(1); push_b(2);
    push_a(3); push_b(4);
    push_a(11); push_b(12);
    push_a(20); push_b(30);
    p0 = pop_cnt; w0 = wr_cnt; d0 = done_cnt;
    go(0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    @(negedge clock);
    check("len0_done_pulse", done, 0);
    check("len0_no_pop", pop_cnt, p0);
    check("len0_no_write", wr_cnt, w0);
    check("len0_one_done", done_cnt, d0 + 1);

    go(4);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    s_full = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    s_full = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wr_en", s_write_enable, 0);
    check("rst_mid_rd_en", a_read_enable, 0);
    check("rst_mid_s_data", s_data, 0);
    check("rst_mid_pops", pop_cnt, p0 + 2);
    check("rst_mid_no_write", wr_cnt, w0);
    w1 = wr_cnt; d0 = done_cnt;
    go(2);
    wait_done(d0);
    check("t6_res0", res[w1], 23);
    check("t6_res1", res[w1 + 1], 50);
    check("t6_count", wr_cnt, w1 + 2);
    check("enables_paired", en_mis, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
